cv32e40p_mult_share_arb: RTL and testbench
==========================================

Name: cv32e40p_mult_share_arb

Overview:
Shares one cv32e40p multiplier instance between two requesters: the core EX stage (port 0) and an auxiliary/APU requester (port 1).
- Per requester: a valid/ready request channel and a one-entry registered response channel.
- Arbitrates between requesters each cycle and locks the grant across multicycle (MULH) operations.
- Drives the multiplier's enable and ex_ready handshake.
- Ensures operands stay stable until the multiplier reports ready.

Parameters:
OP_W, 107, width of packed operand bundle (operator 3, op_a/op_b/op_c 3x32, imm 5, short_subword 1, short_signed 2)
RES_W, 32, result width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req0_valid_i  in  1  requester 0 has an operation
req0_ready_o  out  1  requester 0 operation accepted (completed) this cycle
req0_op_i  in  OP_W  requester 0 operand bundle
resp0_valid_o  out  1  requester 0 result held
resp0_result_o  out  RES_W  requester 0 result
resp0_ready_i  in  1  requester 0 consumes result
req1_valid_i, req1_ready_o, req1_op_i, resp1_valid_o, resp1_result_o, resp1_ready_i  as port 0, for requester 1
mult_enable_o  out  1  multiplier enable_i
mult_op_o  out  OP_W  bundle to multiplier operand/operator inputs
mult_ready_i  in  1  multiplier ready_o
mult_multicycle_i  in  1  multiplier multicycle_o
mult_result_i  in  RES_W  multiplier result_o
mult_ex_ready_o  out  1  multiplier ex_ready_i

Behaviour:
- Reset values: state ARB, rr_ptr=0, lock_id=0, resp*_valid_o=0, resp*_result_o=0.
- All outputs except resp* are combinational from state.
- Eligibility: reqN_valid_i && (!respN_valid_o || respN_ready_i).
  - A full response buffer being drained in the same cycle counts as free.
- State ARB:
  - Pick the winner among eligible requesters; rr_ptr names the preferred requester.
  - mult_op_o = winner bundle; mult_enable_o = 1 if there is a winner.
  - With no winner: mult_op_o = 0 and mult_enable_o = 0.
  - mult_ex_ready_o = 1 in ARB.
  - If there is a winner and mult_ready_i=1 (single-cycle op):
    - reqW_ready_o=1.
    - respW buffer loads mult_result_i, so resp valid appears the next cycle.
    - rr_ptr <= ~W.
  - If there is a winner and mult_ready_i=0 (MULH start): lock_id <= W, go to BUSY; reqW_ready_o=0.
- State BUSY:
  - mult_op_o = locked bundle; mult_enable_o=0; mult_ex_ready_o=1.
  - When mult_ready_i=1 (multiplier in FINISH):
    - req[lock]_ready_o=1 and the locked response buffer loads mult_result_i.
    - rr_ptr <= ~lock_id; return to ARB.
  - The locked buffer is guaranteed free: it was free at grant and only that requester fills it.
  - The non-locked requester sees ready=0 throughout BUSY.
- Latency:
  - Single-cycle op: request accepted in cycle N, resp valid in N+1.
  - MULH: grant in N, STEP0 N+1, STEP1 N+2, STEP2 N+3, FINISH N+4 (req ready), resp valid N+5.
  - Back-to-back single-cycle ops sustain 1 per cycle.
- Response buffer, per requester:
  - Load sets valid; resp_ready_i with valid clears it.
  - Load and drain in the same cycle keeps valid=1 with the new data.
  - Result is held stable while valid && !ready.
- Protocol:
  - A requester must hold valid and bundle stable until ready.
  - Dropping valid or changing the bundle in BUSY is a violation, flagged by a simulation assertion.
  - mult_multicycle_i=1 while in ARB is also an assertion failure.
- Reset mid-operation: async return to ARB and all buffers emptied; the multiplier shares rst_n and returns to IDLE together with the arbiter.

Optional Feature:
MULT_ARB_FIXED_PRIO_EN
- Defined: requester 0 always wins when eligible; rr_ptr is removed.
- Undefined: round-robin as specified above.

Decomposition:
- Package cv32e40p_mult_arb_pkg holds:
  - state typedef (ARB, BUSY)
  - NREQ=2
  - requester-id localparams
  - default OP_W
- One natural sub-module: cv32e40p_mult_resp_buf, a one-entry valid/ready register instantiated per requester.

Test Plan:
1. Reset, then req0 MAC32 (op_a=3, op_b=5, op_c=7) -> req0_ready in accept cycle, resp0 valid next cycle with 22; resp1 stays 0.
2. Both request MAC32 every cycle, both resp_ready=1 -> grants alternate 0,1,0,1; no cycle has mult_enable_o without a ready.
3. req1 MULH (0x80000000 x 2, signed) and req0 valid concurrently -> lock on 1, req0_ready=0 for 5 cycles, resp1 = 0xFFFFFFFF at N+5, then req0 granted.
4. resp0 full with resp0_ready=0, req0 and req1 valid -> only req1 served; raise resp0_ready -> req0 served in the same cycle as the drain.
5. Assert rst_n low during MULH STEP1 -> all resp valid 0, state ARB; after reset a fresh MUL_I completes normally.
6. Build with MULT_ARB_FIXED_PRIO_EN, both continuously valid -> req0 wins every cycle and req1 is never granted.

Source files
------------

// File: rtl/cv32e40p_mult_arb_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
// The packed operand bundle layout matches the cv32e40p multiplier inputs.
package cv32e40p_mult_arb_pkg;

  localparam int NREQ      = 2;
  localparam int OP_W_DEF  = 107;
  localparam int RES_W_DEF = 32;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic {
    ARB  = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Multiplier operator encodings used by the requesters
  localparam logic [2:0] MUL_MAC32 = 3'b000;
  localparam logic [2:0] MUL_MSU32 = 3'b001;
  localparam logic [2:0] MUL_I     = 3'b010;
  localparam logic [2:0] MUL_H     = 3'b110;

  typedef struct packed {
    logic [2:0]  operator;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_c;
    logic [4:0]  imm;
    logic        short_subword;
    logic [1:0]  short_signed;
  } mult_op_t;

endpackage

// File: rtl/cv32e40p_mult_resp_buf.sv
// One-entry registered response buffer with a valid/ready drain side.
// A load in the same cycle as a drain keeps the entry valid with new data.
module cv32e40p_mult_resp_buf
  import cv32e40p_mult_arb_pkg::*;
#(
  parameter int RES_W = RES_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [RES_W-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [RES_W-1:0] o_data
);

  logic             r_valid;
  logic [RES_W-1:0] r_data;

  // NOTE: the data word is reset because its zero value is visible on the
  // port after reset; a deep storage array would be left unreset instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/cv32e40p_mult_share_arb.sv
// Shares one cv32e40p multiplier between the EX stage (port 0) and an APU port.
// Define MULT_ARB_FIXED_PRIO_EN to make port 0 win always; default is round-robin.
module cv32e40p_mult_share_arb
  import cv32e40p_mult_arb_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int RES_W = RES_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [OP_W-1:0]  req0_op_i,
  output logic             resp0_valid_o,
  output logic [RES_W-1:0] resp0_result_o,
  input  logic             resp0_ready_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [OP_W-1:0]  req1_op_i,
  output logic             resp1_valid_o,
  output logic [RES_W-1:0] resp1_result_o,
  input  logic             resp1_ready_i,
  output logic             mult_enable_o,
  output logic [OP_W-1:0]  mult_op_o,
  input  logic             mult_ready_i,
  input  logic             mult_multicycle_i,
  input  logic [RES_W-1:0] mult_result_i,
  output logic             mult_ex_ready_o
);

  arb_state_e      r_state;
  arb_state_e      w_next_state;
  logic            r_lock_id;
  logic            w_elig0;
  logic            w_elig1;
  logic            w_has_win;
  logic            w_win;
  logic            w_done_id;
  logic [NREQ-1:0] w_done;
  logic [OP_W-1:0] w_win_op;
  logic [OP_W-1:0] w_lock_op;

  // A full buffer that drains this cycle can take the next result.
  assign w_elig0   = req0_valid_i && (!resp0_valid_o || resp0_ready_i);
  assign w_elig1   = req1_valid_i && (!resp1_valid_o || resp1_ready_i);
  assign w_has_win = w_elig0 || w_elig1;

`ifdef MULT_ARB_FIXED_PRIO_EN
  assign w_win = w_elig0 ? REQ0 : REQ1;
`else
  logic r_rr_ptr;

  assign w_win = (w_elig0 && w_elig1) ? r_rr_ptr : (w_elig0 ? REQ0 : REQ1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= REQ0;
    end else if (|w_done) begin
      r_rr_ptr <= ~w_done_id;
    end
  end
`endif

  assign w_win_op  = (w_win == REQ1) ? req1_op_i : req0_op_i;
  assign w_lock_op = (r_lock_id == REQ1) ? req1_op_i : req0_op_i;

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state  = r_state;
    mult_enable_o = 1'b0;
    mult_op_o     = '0;
    w_done        = '0;
    w_done_id     = w_win;
    case (r_state)
      ARB: begin
        if (w_has_win) begin
          mult_enable_o = 1'b1;
          mult_op_o     = w_win_op;
          if (mult_ready_i) begin
            w_done[w_win] = 1'b1;
          end else begin
            w_next_state = BUSY;
          end
        end
      end
      BUSY: begin
        // Operands stay pinned to the locked requester until FINISH.
        mult_op_o = w_lock_op;
        w_done_id = r_lock_id;
        if (mult_ready_i) begin
          w_done[r_lock_id] = 1'b1;
          w_next_state      = ARB;
        end
      end
      default: w_next_state = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB;
      r_lock_id <= REQ0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ARB && w_has_win && !mult_ready_i) begin
        r_lock_id <= w_win;
      end
    end
  end

  assign req0_ready_o    = w_done[0];
  assign req1_ready_o    = w_done[1];
  assign mult_ex_ready_o = 1'b1;

  cv32e40p_mult_resp_buf #(.RES_W(RES_W)) u_resp_buf0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_done[0]),
    .i_data  (mult_result_i),
    .i_ready (resp0_ready_i),
    .o_valid (resp0_valid_o),
    .o_data  (resp0_result_o)
  );

  cv32e40p_mult_resp_buf #(.RES_W(RES_W)) u_resp_buf1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_done[1]),
    .i_data  (mult_result_i),
    .i_ready (resp1_ready_i),
    .o_valid (resp1_valid_o),
    .o_data  (resp1_result_o)
  );

  // Requester protocol: the locked requester holds valid and bundle in BUSY.
  a_lock0_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == BUSY && r_lock_id == REQ0) |-> (req0_valid_i && $stable(req0_op_i)));
  a_lock1_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == BUSY && r_lock_id == REQ1) |-> (req1_valid_i && $stable(req1_op_i)));
  a_no_multicycle_in_arb : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ARB) |-> !mult_multicycle_i);

endmodule

// File: tb/tb_cv32e40p_mult_share_arb.sv
// Scoreboard bench for the shared-multiplier arbiter with a behavioural
// cv32e40p multiplier (single-cycle ops and a 4-step MULH sequence).
module tb_cv32e40p_mult_share_arb;
  import cv32e40p_mult_arb_pkg::*;

  localparam int OP_W  = OP_W_DEF;
  localparam int RES_W = RES_W_DEF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid_i, req0_ready_o, resp0_valid_o, resp0_ready_i;
  logic             req1_valid_i, req1_ready_o, resp1_valid_o, resp1_ready_i;
  logic [OP_W-1:0]  req0_op_i, req1_op_i, mult_op_o;
  logic [RES_W-1:0] resp0_result_o, resp1_result_o, mult_result_i;
  logic             mult_enable_o, mult_ready_i, mult_multicycle_i, mult_ex_ready_o;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp0_cur, exp1_cur;
  logic        s_r0, s_r1, s_en, s_rv0, s_rv1, s_exr, acc0, acc1;
  logic [31:0] s_res0, s_res1;

  // Hand-computed MAC32 vectors: a*b+c (mod 2^32)
  logic [31:0] t0a[4] = '{32'd2, 32'd4, 32'd10, 32'hFFFF_FFFF};
  logic [31:0] t0b[4] = '{32'd3, 32'd4, 32'd10, 32'd1};
  logic [31:0] t0c[4] = '{32'd1, 32'd0, 32'd5,  32'd1};
  logic [31:0] t0e[4] = '{32'd7, 32'd16, 32'd105, 32'd0};
  logic [31:0] t1a[4] = '{32'd6, 32'd1, 32'd100, 32'h0001_0000};
  logic [31:0] t1b[4] = '{32'd7, 32'd1, 32'd3,   32'h0001_0000};
  logic [31:0] t1c[4] = '{32'd0, 32'd1, 32'd0,   32'd3};
  logic [31:0] t1e[4] = '{32'd42, 32'd2, 32'd300, 32'd3};

  always #5 clk = ~clk;

  cv32e40p_mult_share_arb #(.OP_W(OP_W), .RES_W(RES_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req0_valid_i      (req0_valid_i),
    .req0_ready_o      (req0_ready_o),
    .req0_op_i         (req0_op_i),
    .resp0_valid_o     (resp0_valid_o),
    .resp0_result_o    (resp0_result_o),
    .resp0_ready_i     (resp0_ready_i),
    .req1_valid_i      (req1_valid_i),
    .req1_ready_o      (req1_ready_o),
    .req1_op_i         (req1_op_i),
    .resp1_valid_o     (resp1_valid_o),
    .resp1_result_o    (resp1_result_o),
    .resp1_ready_i     (resp1_ready_i),
    .mult_enable_o     (mult_enable_o),
    .mult_op_o         (mult_op_o),
    .mult_ready_i      (mult_ready_i),
    .mult_multicycle_i (mult_multicycle_i),
    .mult_result_i     (mult_result_i),
    .mult_ex_ready_o   (mult_ex_ready_o)
  );

  // ---------------- behavioural multiplier ----------------
  function automatic logic [31:0] mult_model(input logic [OP_W-1:0] bits);
    mult_op_t           o;
    logic signed [32:0] sa, sb;
    logic signed [65:0] p;
    logic [31:0]        s;
    o = bits;
    case (o.operator)
      MUL_MAC32: return o.op_a * o.op_b + o.op_c;
      MUL_MSU32: return o.op_c - o.op_a * o.op_b;
      MUL_I: begin
        s = {16'd0, o.op_a[15:0]} * {16'd0, o.op_b[15:0]};
        return s >> o.imm;
      end
      MUL_H: begin
        sa = {o.short_signed[0] & o.op_a[31], o.op_a};
        sb = {o.short_signed[1] & o.op_b[31], o.op_b};
        p  = sa * sb;
        return p[63:32];
      end
      default: return 32'd0;
    endcase
  endfunction

  mult_op_t   w_mop;
  logic [2:0] m_st;  // 0 IDLE, 1 STEP0, 2 STEP1, 3 STEP2, 4 FINISH
  assign w_mop = mult_op_o;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 3'd0;
    end else if (m_st == 3'd0) begin
      if (mult_enable_o && w_mop.operator == MUL_H) m_st <= 3'd1;
    end else if (m_st == 3'd4) begin
      m_st <= 3'd0;
    end else begin
      m_st <= m_st + 3'd1;
    end
  end

  assign mult_ready_i      = (m_st == 3'd0) ? !(mult_enable_o && w_mop.operator == MUL_H)
                                            : (m_st == 3'd4);
  assign mult_multicycle_i = (m_st != 3'd0);
  assign mult_result_i     = mult_model(mult_op_o);

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares each consumed response with the queue head
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n) begin
      if (resp0_valid_o && resp0_ready_i) begin
        if (q0.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL resp0_unexpected: got 0x%08h expected no response", resp0_result_o);
        end else begin
          e = q0.pop_front();
          check("resp0_result", resp0_result_o, e);
        end
      end
      if (resp1_valid_o && resp1_ready_i) begin
        if (q1.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL resp1_unexpected: got 0x%08h expected no response", resp1_result_o);
        end else begin
          e = q1.pop_front();
          check("resp1_result", resp1_result_o, e);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [OP_W-1:0] mk(input logic [2:0] opr, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c,
                                         input logic [4:0] imm, input logic [1:0] ss);
    mult_op_t o;
    o.operator      = opr;
    o.op_a          = a;
    o.op_b          = b;
    o.op_c          = c;
    o.imm           = imm;
    o.short_subword = 1'b0;
    o.short_signed  = ss;
    return o;
  endfunction

  task automatic set0(input int i);
    req0_op_i = mk(MUL_MAC32, t0a[i], t0b[i], t0c[i], 5'd0, 2'd0);
    exp0_cur  = t0e[i];
  endtask

  task automatic set1(input int i);
    req1_op_i = mk(MUL_MAC32, t1a[i], t1b[i], t1c[i], 5'd0, 2'd0);
    exp1_cur  = t1e[i];
  endtask

  // One cycle: sample at negedge, record acceptances, return just after posedge
  task automatic step();
    @(negedge clk);
    s_r0   = req0_ready_o;
    s_r1   = req1_ready_o;
    s_en   = mult_enable_o;
    s_exr  = mult_ex_ready_o;
    s_rv0  = resp0_valid_o;
    s_rv1  = resp1_valid_o;
    s_res0 = resp0_result_o;
    s_res1 = resp1_result_o;
    acc0   = req0_valid_i && req0_ready_o;
    acc1   = req1_valid_i && req1_ready_o;
    if (acc0) q0.push_back(exp0_cur);
    if (acc1) q1.push_back(exp1_cur);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   i0, i1;
    logic exp_w;
    req0_valid_i  = 1'b0;
    req1_valid_i  = 1'b0;
    req0_op_i     = '0;
    req1_op_i     = '0;
    resp0_ready_i = 1'b1;
    resp1_ready_i = 1'b1;
    exp0_cur      = '0;
    exp1_cur      = '0;

    // Reset state
    #12;
    checkb("rst_resp0_valid", resp0_valid_o, 1'b0);
    checkb("rst_resp1_valid", resp1_valid_o, 1'b0);
    check("rst_resp0_result", resp0_result_o, 32'd0);
    check("rst_resp1_result", resp1_result_o, 32'd0);
    checkb("rst_state_arb", dut.r_state == ARB, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single MAC32 on port 0
    req0_op_i = mk(MUL_MAC32, 32'd3, 32'd5, 32'd7, 5'd0, 2'd0);
    exp0_cur  = 32'd22;
    req0_valid_i = 1'b1;
    step();
    checkb("t1_req0_ready", s_r0, 1'b1);
    checkb("t1_enable", s_en, 1'b1);
    checkb("t1_resp0_not_yet", s_rv0, 1'b0);
    req0_valid_i = 1'b0;
    step();
    checkb("t1_resp0_valid", s_rv0, 1'b1);
    checkb("t1_resp1_idle", s_rv1, 1'b0);
    check("t1_resp1_zero", s_res1, 32'd0);

    // 2 (and 6 under fixed priority): both ports stream MAC32 ops
    i0 = 0; i1 = 0;
    set0(i0); set1(i1);
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
`ifdef MULT_ARB_FIXED_PRIO_EN
    exp_w = REQ0;
`else
    exp_w = REQ1;
`endif
    for (int k = 0; k < 8; k++) begin
      step();
      checkb("t2_req0_grant", s_r0, exp_w == REQ0);
      checkb("t2_req1_grant", s_r1, exp_w == REQ1);
      checkb("t2_enable_without_ready", s_en && !(s_r0 || s_r1), 1'b0);
      if (acc0) begin i0 = (i0 + 1) % 4; set0(i0); end
      if (acc1) begin i1 = (i1 + 1) % 4; set1(i1); end
`ifndef MULT_ARB_FIXED_PRIO_EN
      exp_w = ~exp_w;
`endif
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    step();

    // 3: MULH on port 1 locks the multiplier while port 0 waits
    req1_op_i = mk(MUL_H, 32'h8000_0000, 32'd2, 32'd0, 5'd0, 2'b11);
    exp1_cur  = 32'hFFFF_FFFF;
    req0_op_i = mk(MUL_MAC32, 32'd2, 32'd3, 32'd1, 5'd0, 2'd0);
    exp0_cur  = 32'd7;
    req1_valid_i = 1'b1;
`ifndef MULT_ARB_FIXED_PRIO_EN
    req0_valid_i = 1'b1;
`endif
    for (int k = 0; k < 5; k++) begin
      step();
      checkb("t3_req0_blocked", s_r0, 1'b0);
      checkb("t3_req1_ready", s_r1, k == 4);
      checkb("t3_enable", s_en, k == 0);
      checkb("t3_ex_ready", s_exr, 1'b1);
      req0_valid_i = 1'b1;
    end
    req1_valid_i = 1'b0;
    step();
    checkb("t3_resp1_valid", s_rv1, 1'b1);
    checkb("t3_req0_granted", s_r0, 1'b1);
    req0_valid_i = 1'b0;
    step();

    // 4: port 0 buffer full and stalled, port 1 keeps being served
    resp0_ready_i = 1'b0;
    req0_op_i = mk(MUL_MAC32, 32'd4, 32'd4, 32'd0, 5'd0, 2'd0);
    exp0_cur  = 32'd16;
    req0_valid_i = 1'b1;
    step();
    checkb("t4_req0_accept", s_r0, 1'b1);
    req0_op_i = mk(MUL_MAC32, 32'd10, 32'd10, 32'd5, 5'd0, 2'd0);
    exp0_cur  = 32'd105;
    req1_op_i = mk(MUL_MAC32, 32'd6, 32'd7, 32'd0, 5'd0, 2'd0);
    exp1_cur  = 32'd42;
    req1_valid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checkb("t4_req0_held_off", s_r0, 1'b0);
      checkb("t4_req1_served", s_r1, 1'b1);
      checkb("t4_resp0_full", s_rv0, 1'b1);
      check("t4_resp0_stable", s_res0, 32'd16);
      req1_op_i = mk(MUL_MAC32, 32'd1, 32'd1, 32'd1, 5'd0, 2'd0);
      exp1_cur  = 32'd2;
    end
    req1_valid_i  = 1'b0;
    resp0_ready_i = 1'b1;
    step();
    checkb("t4_req0_on_drain", s_r0, 1'b1);
    req0_valid_i = 1'b0;
    step();
    checkb("t4_resp0_refilled", s_rv0, 1'b1);
    check("t4_resp0_new_data", s_res0, 32'd105);
    step();

    // 5: reset during MULH STEP1, then a fresh MUL_I
    req0_op_i = mk(MUL_H, 32'd3, 32'd4, 32'd0, 5'd0, 2'b00);
    exp0_cur  = 32'd0;
    req0_valid_i = 1'b1;
    step();
    checkb("t5_mulh_start_enable", s_en, 1'b1);
    checkb("t5_mulh_not_ready", s_r0, 1'b0);
    step();
    checkb("t5_step0_not_ready", s_r0, 1'b0);
    rst_n = 1'b0;
    req0_valid_i = 1'b0;
    #2;
    checkb("t5_rst_resp0_valid", resp0_valid_o, 1'b0);
    checkb("t5_rst_resp1_valid", resp1_valid_o, 1'b0);
    check("t5_rst_resp0_result", resp0_result_o, 32'd0);
    checkb("t5_rst_state_arb", dut.r_state == ARB, 1'b1);
    checkb("t5_rst_enable", mult_enable_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req1_op_i = mk(MUL_I, 32'd6, 32'd7, 32'd0, 5'd1, 2'b00);
    exp1_cur  = 32'd21;
    req1_valid_i = 1'b1;
    step();
    checkb("t5_mul_i_accept", s_r1, 1'b1);
    req1_valid_i = 1'b0;
    step();
    checkb("t5_mul_i_resp_valid", s_rv1, 1'b1);
    step();

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
